// File: rtl/dma_burst_ctrl.sv
// dma_burst_ctrl: splits a DMA read transfer into AXI INCR bursts and
// issues them one at a time to the read engine. Beats returned by the
// engine pass combinationally to the sink.
// Optional feature macro: DMA_BURST_4K_SPLIT_EN (bursts stop at 4 KB pages).
// Address/length widths come from dma_axi.vh (`AXI_ADDR_W, `AXI_LEN_W);
// the defaults below apply when that header has not been read first.
// Ports:
//   clk, rst                   clock, async active-high reset
//   cfg_start/addr/words       transfer request from the config block
//   cfg_busy/done/error        transfer status to the config block
//   rd_valid/addr/len          burst request to the read engine
//   rd_dma_ready               engine idle level
//   rd_ready/rd_rdata          beat strobe and data from the engine
//   out_valid/out_data         beat strobe and data to the sink

`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module dma_burst_ctrl #(
    parameter int DMA_DATA_WIDTH = 32,
    parameter int MAX_BURST      = 256,
    parameter int CNT_W          = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_start,
    input  logic [`AXI_ADDR_W-1:0]    cfg_addr,
    input  logic [CNT_W-1:0]          cfg_words,
    output logic                      cfg_busy,
    output logic                      cfg_done,
    output logic                      cfg_error,
    output logic                      rd_valid,
    output logic [`AXI_ADDR_W-1:0]    rd_addr,
    output logic [`AXI_LEN_W-1:0]     rd_len,
    input  logic                      rd_dma_ready,
    input  logic                      rd_ready,
    input  logic [DMA_DATA_WIDTH-1:0] rd_rdata,
    output logic                      out_valid,
    output logic [DMA_DATA_WIDTH-1:0] out_data
);

    localparam int AW = `AXI_ADDR_W;
    localparam int LW = `AXI_LEN_W;
    localparam int B  = DMA_DATA_WIDTH / 8;
    localparam int LB = $clog2(B);
    localparam int BW = LW + 1;
    // Scratch width: holds the word count, a page beat count and a burst.
    localparam int W0 = (CNT_W > 13) ? CNT_W : 13;
    localparam int WW = (W0 > BW) ? W0 : BW;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE,
        DATA
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   addr, addr_n;
    logic [CNT_W-1:0] remaining, rem_n;
    logic [BW-1:0]   burst, burst_n;
    logic [BW-1:0]   beat, beat_n;
    logic            busy_n, done_n, error_n;
    logic            valid_n;
    logic [AW-1:0]   rd_addr_n;
    logic [LW-1:0]   rd_len_n;

    logic [WW-1:0]   rem_w, cap_w, burst_w;
    logic            misaligned;
    logic            last_beat;
    logic [AW-1:0]   addr_next;
    logic [CNT_W-1:0] rem_next;

    assign out_valid = rd_ready;
    assign out_data  = rd_rdata;

    assign misaligned = |(cfg_addr & AW'(B - 1));
    assign addr_next  = addr + (AW'(burst) << LB);
    assign rem_next   = remaining - CNT_W'(burst);

`ifdef DMA_BURST_4K_SPLIT_EN
    logic [WW-1:0] page_w;
`endif

    always_comb begin
        rem_w = WW'(remaining);
        cap_w = (rem_w > WW'(MAX_BURST)) ? WW'(MAX_BURST) : rem_w;
`ifdef DMA_BURST_4K_SPLIT_EN
        page_w  = WW'((13'd4096 - {1'b0, addr[11:0]}) >> LB);
        burst_w = (page_w < cap_w) ? page_w : cap_w;
`else
        burst_w = cap_w;
`endif
    end

    // The beat that completes the current burst, wherever it lands.
    always_comb begin
        last_beat = 1'b0;
        if (rd_ready) begin
            if (state == ISSUE)
                last_beat = (burst == BW'(1));
            else if (state == DATA)
                last_beat = ((beat + BW'(1)) == burst);
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = addr;
        rem_n     = remaining;
        burst_n   = burst;
        beat_n    = beat;
        busy_n    = cfg_busy;
        done_n    = 1'b0;
        error_n   = cfg_error;
        valid_n   = rd_valid;
        rd_addr_n = rd_addr;
        rd_len_n  = rd_len;

        // Busy covers the done cycle so a start there is refused.
        if (cfg_done && cfg_busy)
            busy_n = 1'b0;

        unique case (state)
            IDLE: begin
                if (cfg_start && !cfg_done) begin
                    addr_n  = cfg_addr;
                    rem_n   = cfg_words;
                    error_n = 1'b0;
                    if (misaligned) begin
                        error_n = 1'b1;
                        done_n  = 1'b1;
                    end else if (cfg_words == '0) begin
                        done_n = 1'b1;
                    end else begin
                        busy_n  = 1'b1;
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                burst_n   = BW'(burst_w);
                beat_n    = '0;
                rd_addr_n = addr;
                rd_len_n  = LW'(burst_w - WW'(1));
                valid_n   = rd_dma_ready;
                state_n   = ISSUE;
            end
            ISSUE: begin
                if (rd_ready) begin
                    valid_n = 1'b0;
                    beat_n  = BW'(1);
                    state_n = DATA;
                end else if (!rd_valid) begin
                    valid_n = rd_dma_ready;
                end
            end
            DATA: begin
                if (rd_ready)
                    beat_n = beat + BW'(1);
            end
            default: state_n = IDLE;
        endcase

        if (last_beat) begin
            addr_n = addr_next;
            rem_n  = rem_next;
            if (rem_next != '0) begin
                state_n = CALC;
            end else begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            burst     <= '0;
            beat      <= '0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            rd_len    <= '0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            remaining <= rem_n;
            burst     <= burst_n;
            beat      <= beat_n;
            cfg_busy  <= busy_n;
            cfg_done  <= done_n;
            cfg_error <= error_n;
            rd_valid  <= valid_n;
            rd_addr   <= rd_addr_n;
            rd_len    <= rd_len_n;
        end
    end

endmodule

// File: doc/dma_burst_ctrl.md
Name: dma_burst_ctrl

Overview:
Upstream sequencer for the DMA AXI read engine. It accepts a whole transfer (start address and word count) from the DMA configuration registers, splits it into AXI INCR bursts, and drives the read engine's valid/addr/dma_len interface one burst at a time. It forwards each returned data beat to the local sink as a single-cycle strobe. It raises busy/done/error status for the configuration block.

Parameters:
DMA_DATA_WIDTH, 32, data beat width in bits; bytes per beat B = DMA_DATA_WIDTH/8 (power of 2, at least 1)
MAX_BURST, 256, maximum beats per burst; 1 <= MAX_BURST <= 2^`AXI_LEN_W
CNT_W, 24, width of the transfer word count

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cfg_start  in  1  one-cycle start pulse; ignored unless idle
cfg_addr  in  `AXI_ADDR_W  transfer byte start address; sampled on cfg_start
cfg_words  in  CNT_W  number of beats to transfer; sampled on cfg_start
cfg_busy  out  1  high from the accepted start until done
cfg_done  out  1  one-cycle pulse at transfer end
cfg_error  out  1  sticky misalignment flag; cleared by the next accepted start
rd_valid  out  1  burst request to the read engine
rd_addr  out  `AXI_ADDR_W  burst byte address
rd_len  out  `AXI_LEN_W  burst beats minus 1
rd_dma_ready  in  1  read engine idle indicator
rd_ready  in  1  read engine beat strobe
rd_rdata  in  DMA_DATA_WIDTH  read engine data
out_valid  out  1  beat strobe to the sink; no backpressure
out_data  out  DMA_DATA_WIDTH  beat data to the sink

Behaviour:
- Widths `AXI_ADDR_W and `AXI_LEN_W come from dma_axi.vh.
- Reset values: all registered outputs 0, state IDLE, internal counters 0.
- out_valid = rd_ready and out_data = rd_rdata, combinationally. There is no buffering because the read engine cannot be stalled.
- States: IDLE, CALC, ISSUE, DATA.
- IDLE:
  - cfg_start=1 registers addr, remaining=cfg_words, and clears cfg_error; cfg_busy goes high next cycle.
  - If cfg_addr[log2(B)-1:0] != 0: set cfg_error, pulse cfg_done next cycle, stay IDLE, busy stays 0.
  - If cfg_words == 0: pulse cfg_done next cycle, stay IDLE, no burst issued.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - burst = min(remaining, MAX_BURST, beats_to_4k), where beats_to_4k = (4096 - addr[11:0]) / B.
  - Register rd_addr = addr and rd_len = burst - 1; go to ISSUE.
- ISSUE:
  - rd_valid=1 while rd_addr and rd_len are held stable.
  - Stay in ISSUE until the first rd_ready. rd_valid is cleared at the clock edge where rd_ready is sampled high. This prevents the engine from seeing a second request, including for 1-beat bursts.
  - A beat in ISSUE counts as beat 1; go to DATA, or straight to burst completion if burst == 1.
- DATA:
  - Each rd_ready increments the beat counter. When the counter reaches burst: addr += burst*B, remaining -= burst.
  - If remaining != 0, go to CALC; else pulse cfg_done, drop cfg_busy, go to IDLE.
- rd_dma_ready is not a handshake input. In ISSUE, rd_valid is asserted only while rd_dma_ready=1 on ISSUE entry; otherwise stay in ISSUE with rd_valid low until rd_dma_ready=1.
- Arithmetic: addr wraps modulo 2^`AXI_ADDR_W. Counters are CNT_W-bit and never underflow, because burst <= remaining.
- Latency: start to rd_valid high is 2 cycles. Last beat to cfg_done is 1 cycle.
- Reset mid-transfer aborts immediately to reset values. In-flight AXI beats are the read engine's responsibility.
- Simultaneous events:
  - cfg_start while busy is ignored.
  - cfg_start on the same cycle as cfg_done is ignored (busy is still high).

Optional Feature:
DMA_BURST_4K_SPLIT_EN
- Defined: the beats_to_4k term is included, so no burst crosses a 4 KB boundary, as AXI requires.
- Undefined: burst = min(remaining, MAX_BURST). Intended only for slaves with no 4 KB rule (e.g. single on-chip RAM). This reduces CALC logic.

Test Plan:
1. addr 0x1000, words 4 -> one burst: rd_addr 0x1000, rd_len 3; 4 out_valid strobes; cfg_done one cycle after 4th beat.
2. addr 0x0, words 600, MAX_BURST 256 -> bursts (0x000, len 255), (0x400, len 255), (0x800, len 87); 600 strobes; one cfg_done.
3. addr 0x0FF0, words 10 -> with split: (0xFF0, len 3) then (0x1000, len 5); without macro: (0xFF0, len 9).
4. words 1 with engine returning the beat 1 cycle after rd_valid -> rd_valid high exactly until that beat's edge, never re-asserted; done.
5. Error and zero cases:
   - addr 0x1002, words 8 -> cfg_error=1, cfg_done pulse, rd_valid never asserted.
   - Next start at addr 0x1000 -> cfg_error cleared.
   - words 0 -> cfg_done pulse, no rd_valid.
6. rst asserted mid-DATA of a 256-beat burst -> all outputs 0 and state IDLE immediately; cfg_start after release runs a full transfer correctly.
